// File: rtl/slug_input_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : slug_input_arbiter
//  Description : Shares one five-button input set (up/down/left/right/centre)
//                between two HPS joystick sources. Each source bit is
//                debounced, ownership is granted to one source at a time,
//                and ownership is released after a period of owner
//                inactivity. All buttons are blanked while the OSD is open.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEB_CYCLES    stable cycles before a debounced bit changes (>=1)
//    IDLE_TIMEOUT  owner-inactive cycles before ownership release (>=2)
//    AUTOFIRE_HALF half-period of the btn_c auto-repeat (>=1)
//  Ports
//    clk_sys      in   1   system clock
//    reset_n      in   1   asynchronous active-low reset
//    joy_a        in   16  source A word: [0]=R [1]=L [2]=D [3]=U [4]=C
//    joy_b        in   16  source B word, same mapping
//    osd_active   in   1   OSD open; blanks buttons, freezes arbitration
//    btn_u/d/l/r  out  1   registered direction buttons to the game
//    btn_c        out  1   registered centre/fire button to the game
//    owner        out  2   00 none, 01 source A, 10 source B
//    grant_pulse  out  1   one-cycle pulse with the first owned cycle
//  Configuration macro
//    SLUG_AUTOFIRE_EN  when defined, a held owner C button auto-repeats on
//                      btn_c with a period of 2*AUTOFIRE_HALF cycles.
// ============================================================================
module slug_input_arbiter #(
    parameter int DEB_CYCLES    = 50000,
    parameter int IDLE_TIMEOUT  = 1 << 24,
    parameter int AUTOFIRE_HALF = 1 << 21
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] joy_a,
    input  logic [15:0] joy_b,
    input  logic        osd_active,
    output logic        btn_u,
    output logic        btn_d,
    output logic        btn_l,
    output logic        btn_r,
    output logic        btn_c,
    output logic [1:0]  owner,
    output logic        grant_pulse
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_OWN_A   = 2'd1;
    localparam logic [1:0] c_ST_OWN_B   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    localparam logic [1:0] c_OWNER_NONE = 2'b00;
    localparam logic [1:0] c_OWNER_A    = 2'b01;
    localparam logic [1:0] c_OWNER_B    = 2'b10;

    // Button bit positions inside the five-bit button vectors.
    localparam int c_BIT_R = 0;
    localparam int c_BIT_L = 1;
    localparam int c_BIT_D = 2;
    localparam int c_BIT_U = 3;
    localparam int c_BIT_C = 4;

    // ------------------------------------------------------------------------
    // Raw inputs: source A in [4:0], source B in [9:5]
    // ------------------------------------------------------------------------
    logic [9:0] w_raw;
    logic [9:0] w_deb;
    logic       w_unused_joy_bits;

    assign w_raw = {joy_b[4:0], joy_a[4:0]};

    // Only the five button bits of each joystick word are meaningful.
    assign w_unused_joy_bits = ^{joy_a[15:5], joy_b[15:5]};

    // ------------------------------------------------------------------------
    // Debounce: one counter per bit. The counter tracks how many consecutive
    // cycles the raw bit has disagreed with the debounced bit; any agreement
    // clears it. The debounced bit only moves after DEB_CYCLES consecutive
    // disagreeing samples, so shorter glitches never reach it. The counter
    // clears on the update, so it never exceeds DEB_CYCLES-1 and cannot wrap.
    // Debounce runs regardless of FSM state or OSD.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_deb
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_bit;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_bit <= 1'b0;
                end else if (w_raw[gi] == r_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    r_bit <= w_raw[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_deb[gi] = r_bit;
        end
    endgenerate

    logic [4:0] w_deb_a;
    logic [4:0] w_deb_b;
    logic       w_act_a;
    logic       w_act_b;

    assign w_deb_a = w_deb[4:0];
    assign w_deb_b = w_deb[9:5];
    assign w_act_a = |w_deb_a;
    assign w_act_b = |w_deb_b;

    // ------------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_owner_act;
    logic                w_idle_expired;
    logic                w_owned;

    // Activity of whichever source currently owns; the other source is not
    // looked at at all while ownership is held.
    always_comb begin
        w_owner_act = 1'b0;
        case (r_state)
            c_ST_OWN_A: w_owner_act = w_act_a;
            c_ST_OWN_B: w_owner_act = w_act_b;
            default:    w_owner_act = 1'b0;
        endcase
    end

    assign w_owned        = (r_state == c_ST_OWN_A) || (r_state == c_ST_OWN_B);
    assign w_idle_expired = w_owned && !w_owner_act && (r_idle_cnt == c_IDLE_LAST);

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. With the OSD open the whole arbitration is frozen,
    // including grants out of IDLE and the exit from RELEASE.
    always_comb begin
        w_state_nxt = r_state;
        if (!osd_active) begin
            case (r_state)
                c_ST_IDLE: begin
                    // Source A wins a simultaneous rise.
                    if (w_act_a) begin
                        w_state_nxt = c_ST_OWN_A;
                    end else if (w_act_b) begin
                        w_state_nxt = c_ST_OWN_B;
                    end
                end
                c_ST_OWN_A,
                c_ST_OWN_B: begin
                    if (w_idle_expired) begin
                        w_state_nxt = c_ST_RELEASE;
                    end
                end
                // One dead cycle between owners; nothing is granted here.
                c_ST_RELEASE: w_state_nxt = c_ST_IDLE;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Inactivity counter. Held while the OSD is open; cleared by owner
    // activity and outside the owned states. It clears on expiry, so it
    // never exceeds IDLE_TIMEOUT-1 and cannot wrap.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (osd_active) begin
            r_idle_cnt <= r_idle_cnt;
        end else if (w_owned && !w_owner_act && !w_idle_expired) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
            r_idle_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (combinational next values, registered below)
    // ------------------------------------------------------------------------
    logic [4:0] w_sel_btn;
    logic [4:0] w_btn_nxt;
    logic [1:0] w_owner_nxt;
    logic       w_grant_nxt;

    always_comb begin
        w_sel_btn   = 5'b0;
        w_owner_nxt = c_OWNER_NONE;
        w_grant_nxt = 1'b0;

        // Buttons come from the state of this cycle, so they follow the
        // owner report by one cycle on a grant.
        if (!osd_active) begin
            case (r_state)
                c_ST_OWN_A: w_sel_btn = w_deb_a;
                c_ST_OWN_B: w_sel_btn = w_deb_b;
                default:    w_sel_btn = 5'b0;
            endcase
        end

        // owner is taken from the next state so that it and grant_pulse
        // appear on the same cycle the FSM enters an owned state.
        case (w_state_nxt)
            c_ST_OWN_A: w_owner_nxt = c_OWNER_A;
            c_ST_OWN_B: w_owner_nxt = c_OWNER_B;
            default:    w_owner_nxt = c_OWNER_NONE;
        endcase

        w_grant_nxt = (r_state == c_ST_IDLE) &&
                      ((w_state_nxt == c_ST_OWN_A) || (w_state_nxt == c_ST_OWN_B));
    end

`ifdef SLUG_AUTOFIRE_EN
    // ------------------------------------------------------------------------
    // Autofire: while the owner's C is passed through, btn_c is gated by a
    // square wave that starts high and toggles every AUTOFIRE_HALF cycles.
    // Any cycle without a passed-through C restarts the phase.
    // ------------------------------------------------------------------------
    localparam int                c_AF_W    = $clog2(AUTOFIRE_HALF + 1);
    localparam logic [c_AF_W-1:0] c_AF_LAST = c_AF_W'(AUTOFIRE_HALF - 1);

    logic [c_AF_W-1:0] r_af_cnt;
    logic              r_af_lvl;
    logic              w_af_held;

    assign w_af_held = w_sel_btn[c_BIT_C];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_af_cnt <= '0;
            r_af_lvl <= 1'b1;
        end else if (!w_af_held) begin
            r_af_cnt <= '0;
            r_af_lvl <= 1'b1;
        end else if (r_af_cnt == c_AF_LAST) begin
            r_af_cnt <= '0;
            r_af_lvl <= ~r_af_lvl;
        end else begin
            r_af_cnt <= r_af_cnt + 1'b1;
        end
    end

    always_comb begin
        w_btn_nxt          = w_sel_btn;
        w_btn_nxt[c_BIT_C] = w_af_held & r_af_lvl;
    end
`else
    // Without autofire btn_c is a plain copy of the owner's debounced C.
    localparam int c_unused_af_half = AUTOFIRE_HALF;

    assign w_btn_nxt = w_sel_btn;
`endif

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    logic [4:0] r_btn;
    logic [1:0] r_owner;
    logic       r_grant;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_btn   <= 5'b0;
            r_owner <= c_OWNER_NONE;
            r_grant <= 1'b0;
        end else begin
            r_btn   <= w_btn_nxt;
            r_owner <= w_owner_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign btn_r       = r_btn[c_BIT_R];
    assign btn_l       = r_btn[c_BIT_L];
    assign btn_d       = r_btn[c_BIT_D];
    assign btn_u       = r_btn[c_BIT_U];
    assign btn_c       = r_btn[c_BIT_C];
    assign owner       = r_owner;
    assign grant_pulse = r_grant;

endmodule
`default_nettype wire
